// File: rtl/game_flow_ctrl.sv
// Game sequencer: start/ready countdown, play with N lives and respawn, pause, end screens.
// Key decisions are taken on press edges; every output is registered from the next state.
module game_flow_ctrl #(
  parameter int LIVES         = 3,
  parameter int READY_TICKS   = 60,
  parameter int RESPAWN_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] key,
  input  logic       frame_tick,
  input  logic       jump_fail,
  input  logic       time_elapsed,
  input  logic       character_landed,
  output logic       start_screen_en,
  output logic       blocks_en,
  output logic       time_bar_en,
  output logic       character_en,
  output logic       points_en,
  output logic       end_screen_en,
  output logic       pause_overlay_en,
  output logic       bg_color_select,
  output logic       jump_left,
  output logic       jump_right,
  output logic       timer_restart,
  output logic       timer_run,
  output logic       end_text_select,
  output logic       life_lost,
  output logic [3:0] lives_left
);

  localparam int MAX_TICKS = (READY_TICKS > RESPAWN_TICKS) ? READY_TICKS : RESPAWN_TICKS;
  localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CW-1:0] READY_LAST   = CW'(READY_TICKS - 1);
  localparam logic [CW-1:0] RESPAWN_LAST = CW'(RESPAWN_TICKS - 1);
  localparam logic [3:0]    LIVES_INIT   = 4'(LIVES);

  typedef enum logic [3:0] {
    S_START   = 4'd0,
    S_PREPARE = 4'd1,
    S_READY   = 4'd2,
    S_IDLE    = 4'd3,
    S_JUMP_L  = 4'd4,
    S_JUMP_R  = 4'd5,
    S_FLY     = 4'd6,
    S_FALL    = 4'd7,
    S_RESPAWN = 4'd8,
    S_PAUSE   = 4'd9,
    S_END_T   = 4'd10,
    S_END_F   = 4'd11
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    lives_q, lives_d;
  logic [1:0]    key_q;
  logic          press_s, space_s, left_s, right_s;
  logic          game_s;

  assign press_s    = (key != 2'b00) && (key != key_q);
  assign space_s    = press_s && (key == 2'b11);
  assign left_s     = press_s && (key == 2'b01);
  assign right_s    = press_s && (key == 2'b10);
  assign lives_left = lives_q;

  // Next-state, tick counter and lives bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    case (state_q)
      S_START: begin
        if (space_s) state_d = S_PREPARE;
        else         state_d = S_START;
      end
      S_PREPARE: begin
        state_d = S_READY;
        lives_d = LIVES_INIT;
      end
      S_READY: begin
        if (frame_tick) begin
          if (cnt_q == READY_LAST) state_d = S_IDLE;
          else                     cnt_d   = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_IDLE: begin
        if (jump_fail)         state_d = S_FALL;
        else if (time_elapsed) state_d = S_END_T;
        else if (space_s)      state_d = S_PAUSE;
        else if (left_s)       state_d = S_JUMP_L;
        else if (right_s)      state_d = S_JUMP_R;
        else                   state_d = S_IDLE;
      end
      S_JUMP_L, S_JUMP_R: state_d = S_FLY;
      S_FLY: begin
        if (character_landed) state_d = S_IDLE;
        else                  state_d = S_FLY;
      end
      S_FALL: begin
        if (character_landed) begin
          // Saturating decrement keeps lives from wrapping if entered with zero
          lives_d = (lives_q != 4'd0) ? (lives_q - 4'd1) : 4'd0;
          state_d = (lives_q <= 4'd1) ? S_END_F : S_RESPAWN;
        end else begin
          state_d = S_FALL;
        end
      end
      S_RESPAWN: begin
        if (frame_tick) begin
          if (cnt_q == RESPAWN_LAST) state_d = S_READY;
          else                       cnt_d   = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_PAUSE: begin
        if (space_s) state_d = S_IDLE;
        else         state_d = S_PAUSE;
      end
      S_END_T, S_END_F: begin
        if (space_s) state_d = S_START;
        else         state_d = state_q;
      end
      default: state_d = S_START;
    endcase
    // Any state change restarts the counter, so a tick on the entry edge is never counted
    if (state_d != state_q) cnt_d = '0;
    else                    cnt_d = cnt_d;
  end

  assign game_s = (state_d != S_START) && (state_d != S_END_T) && (state_d != S_END_F);

  // State registers and outputs decoded from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_START;
      cnt_q            <= '0;
      lives_q          <= LIVES_INIT;
      key_q            <= 2'b00;
      start_screen_en  <= 1'b1;
      blocks_en        <= 1'b0;
      time_bar_en      <= 1'b0;
      character_en     <= 1'b0;
      points_en        <= 1'b0;
      end_screen_en    <= 1'b0;
      pause_overlay_en <= 1'b0;
      bg_color_select  <= 1'b0;
      jump_left        <= 1'b0;
      jump_right       <= 1'b0;
      timer_restart    <= 1'b0;
      timer_run        <= 1'b0;
      end_text_select  <= 1'b0;
      life_lost        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      lives_q          <= lives_d;
      key_q            <= key;
      start_screen_en  <= (state_d == S_START);
      blocks_en        <= game_s;
      time_bar_en      <= game_s;
      character_en     <= game_s;
      points_en        <= game_s;
      end_screen_en    <= (state_d == S_END_T) || (state_d == S_END_F);
      pause_overlay_en <= (state_d == S_PAUSE);
      bg_color_select  <= game_s;
      jump_left        <= (state_d == S_JUMP_L);
      jump_right       <= (state_d == S_JUMP_R);
      timer_restart    <= (state_d == S_PREPARE) ||
                          ((state_q == S_RESPAWN) && (state_d == S_READY));
      timer_run        <= (state_d == S_IDLE) || (state_d == S_JUMP_L) ||
                          (state_d == S_JUMP_R) || (state_d == S_FLY) || (state_d == S_FALL);
      end_text_select  <= (state_d == S_END_F);
      life_lost        <= (state_q == S_FALL) && character_landed;
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: constant vector table, directed corner sequences and
// randomized play checked every cycle against a phase-name reference model.
module tb_game_flow_ctrl;

  localparam int LIVES         = 3;
  localparam int READY_TICKS   = 60;
  localparam int RESPAWN_TICKS = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] key = 2'b00;
  logic       frame_tick = 1'b0, jump_fail = 1'b0, time_elapsed = 1'b0, character_landed = 1'b0;
  logic       start_screen_en, blocks_en, time_bar_en, character_en, points_en;
  logic       end_screen_en, pause_overlay_en, bg_color_select, jump_left, jump_right;
  logic       timer_restart, timer_run, end_text_select, life_lost;
  logic [3:0] lives_left;

  int tests = 0;
  int fails = 0;

  game_flow_ctrl #(.LIVES(LIVES), .READY_TICKS(READY_TICKS), .RESPAWN_TICKS(RESPAWN_TICKS)) dut (
    .clk(clk), .rst(rst), .key(key), .frame_tick(frame_tick), .jump_fail(jump_fail),
    .time_elapsed(time_elapsed), .character_landed(character_landed),
    .start_screen_en(start_screen_en), .blocks_en(blocks_en), .time_bar_en(time_bar_en),
    .character_en(character_en), .points_en(points_en), .end_screen_en(end_screen_en),
    .pause_overlay_en(pause_overlay_en), .bg_color_select(bg_color_select),
    .jump_left(jump_left), .jump_right(jump_right), .timer_restart(timer_restart),
    .timer_run(timer_run), .end_text_select(end_text_select), .life_lost(life_lost),
    .lives_left(lives_left)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] pack(input logic st, gm, en, pa, jl, jr, rs, rn, tx, ll,
                                       input logic [3:0] lv);
    return {st, gm, gm, gm, gm, en, pa, gm, jl, jr, rs, rn, tx, ll, lv};
  endfunction

  function automatic logic [17:0] actual();
    return {start_screen_en, blocks_en, time_bar_en, character_en, points_en, end_screen_en,
            pause_overlay_en, bg_color_select, jump_left, jump_right, timer_restart, timer_run,
            end_text_select, life_lost, lives_left};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: named game phase, remaining-tick countdown, lives as an integer
  string      ph = "start";
  int         m_lives = LIVES;
  int         rem = 0;
  logic [1:0] pk = 2'b00;
  logic       m_lost = 1'b0, m_rsx = 1'b0;

  task automatic model_step(input logic r, input logic [1:0] k, input logic f, j, t, c);
    logic press, sp, lf, rt;
    m_lost = 1'b0;
    m_rsx  = 1'b0;
    if (r) begin
      ph = "start"; m_lives = LIVES; rem = 0; pk = 2'b00;
      return;
    end
    press = (k != 2'b00) && (k != pk);
    pk = k;
    sp = press && (k == 2'b11);
    lf = press && (k == 2'b01);
    rt = press && (k == 2'b10);
    if (ph == "start") begin
      if (sp) ph = "prepare";
    end else if (ph == "prepare") begin
      ph = "ready"; m_lives = LIVES; rem = READY_TICKS;
    end else if (ph == "ready") begin
      if (f) begin
        rem--;
        if (rem == 0) ph = "idle";
      end
    end else if (ph == "idle") begin
      if (j) ph = "fall";
      else if (t) ph = "end_t";
      else if (sp) ph = "pause";
      else if (lf) ph = "jump_l";
      else if (rt) ph = "jump_r";
    end else if (ph == "jump_l" || ph == "jump_r") begin
      ph = "fly";
    end else if (ph == "fly") begin
      if (c) ph = "idle";
    end else if (ph == "fall") begin
      if (c) begin
        if (m_lives > 0) m_lives--;
        m_lost = 1'b1;
        if (m_lives == 0) ph = "end_f";
        else begin ph = "respawn"; rem = RESPAWN_TICKS; end
      end
    end else if (ph == "respawn") begin
      if (f) begin
        rem--;
        if (rem == 0) begin ph = "ready"; rem = READY_TICKS; m_rsx = 1'b1; end
      end
    end else if (ph == "pause") begin
      if (sp) ph = "idle";
    end else begin
      if (sp) ph = "start";
    end
  endtask

  function automatic logic [17:0] model_exp();
    logic gm, rn;
    gm = !(ph == "start" || ph == "end_t" || ph == "end_f");
    rn = (ph == "idle" || ph == "jump_l" || ph == "jump_r" || ph == "fly" || ph == "fall");
    return pack(ph == "start", gm, ph == "end_t" || ph == "end_f", ph == "pause",
                ph == "jump_l", ph == "jump_r", (ph == "prepare") || m_rsx, rn,
                ph == "end_f", m_lost, 4'(m_lives));
  endfunction

  // One clock: drive at negedge, advance model at posedge, compare at next negedge
  task automatic cycle(input logic r, input logic [1:0] k, input logic f, j, t, c);
    rst = r; key = k; frame_tick = f; jump_fail = j; time_elapsed = t; character_landed = c;
    @(posedge clk);
    model_step(r, k, f, j, t, c);
    @(negedge clk);
    check("model", 32'(actual()), 32'(model_exp()));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_game();
    cycle(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(READY_TICKS);
    check("start_game_idle", 32'(timer_run), 32'd1);
  endtask

  task automatic fall_once(input logic [3:0] exp_lives);
    cycle(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("life_lost_pulse", 32'(life_lost), 32'd1);
    check("lives_after_fall", 32'(lives_left), 32'(exp_lives));
  endtask

  typedef struct {
    logic        r;
    logic [1:0]  k;
    logic        f;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[6];
  int   jl_cnt;
  logic [1:0] rk;

  initial begin
    tbl[0] = '{1'b1, 2'b00, 1'b0, pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd3)};
    tbl[1] = '{1'b0, 2'b11, 1'b0, pack(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4'd3)};
    tbl[2] = '{1'b0, 2'b11, 1'b1, pack(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd3)};
    tbl[3] = '{1'b0, 2'b00, 1'b1, pack(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd3)};
    tbl[4] = '{1'b0, 2'b11, 1'b0, pack(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd3)};
    tbl[5] = '{1'b0, 2'b00, 1'b1, pack(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd3)};

    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].r, tbl[i].k, tbl[i].f, 1'b0, 1'b0, 1'b0);
      check($sformatf("table[%0d]", i), 32'(actual()), 32'(tbl[i].exp));
    end

    // Two ticks counted so far; the 60th tick enters play
    ticks(READY_TICKS - 3);
    check("ready_before_last_tick", 32'(timer_run), 32'd0);
    ticks(1);
    check("idle_timer_run", 32'(timer_run), 32'd1);
    check("idle_lives", 32'(lives_left), 32'd3);

    // Held left key produces a single jump
    jl_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      jl_cnt += int'(jump_left);
    end
    check("jump_left_once", 32'(jl_cnt), 32'd1);
    cycle(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    check("no_second_jump", 32'(jump_left), 32'd0);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pause freezes the timer and ignores other keys
    cycle(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pause_overlay", 32'(pause_overlay_en), 32'd1);
    check("pause_timer_frozen", 32'(timer_run), 32'd0);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    check("pause_ignores_left", 32'(jump_left), 32'd0);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    check("resume_timer_run", 32'(timer_run), 32'd1);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Two falls, each followed by respawn and a fresh countdown
    fall_once(4'd2);
    ticks(RESPAWN_TICKS);
    check("respawn_restart", 32'(timer_restart), 32'd1);
    ticks(READY_TICKS);
    fall_once(4'd1);
    ticks(RESPAWN_TICKS + READY_TICKS);

    // Reset in flight with one life left
    cycle(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fly_lives", 32'(lives_left), 32'd1);
    cycle(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midgame_reset", 32'(actual()), 32'(pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd3)));

    // Time-out wins over a same-cycle left press
    start_game();
    cycle(1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    check("timeout_no_jump", 32'(jump_left), 32'd0);
    check("timeout_end_screen", 32'({end_screen_en, end_text_select}), 32'b10);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    check("end_to_start", 32'(start_screen_en), 32'd1);
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Three falls end the game on the fell screen; lives stay at zero
    start_game();
    fall_once(4'd2);
    ticks(RESPAWN_TICKS + READY_TICKS);
    fall_once(4'd1);
    ticks(RESPAWN_TICKS + READY_TICKS);
    fall_once(4'd0);
    check("fell_end_screen", 32'({end_screen_en, end_text_select}), 32'b11);
    cycle(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
    check("no_underflow", 32'(lives_left), 32'd0);

    // Randomized play against the model
    rk = 2'b00;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) rk = 2'($urandom_range(0, 3));
      cycle($urandom_range(0, 299) == 0, rk, $urandom_range(0, 2) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
